// File: rtl/multi_oscillator.sv
// Bank of independent sawtooth/triangle oscillators with tick and square outputs.
// Define OSC_SYNC_EN to add the per-channel hard-sync input port.
module multi_oscillator #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       mode,
`ifdef OSC_SYNC_EN
    input  logic [CHANNELS-1:0]       sync,
`endif
    input  logic [CHANNELS*WIDTH-1:0] divider,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       square
);

    logic [CHANNELS-1:0] sync_req;

`ifdef OSC_SYNC_EN
    assign sync_req = sync;
`else
    assign sync_req = '0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             dir_q, dir_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;

        assign div = divider[i*WIDTH +: WIDTH];

        always_comb begin
            cnt_d  = cnt_q;
            dir_d  = dir_q;
            tick_d = 1'b0;
            sq_d   = sq_q;
            if (!en[i] || sync_req[i]) begin
                cnt_d = WIDTH'(1);
                dir_d = 1'b0;
                sq_d  = 1'b0;
            end else if (div <= WIDTH'(1)) begin
                // Degenerate period: every enabled cycle is a full period.
                cnt_d  = WIDTH'(1);
                tick_d = 1'b1;
                if (mode[i]) begin
                    dir_d = ~dir_q;
                    sq_d  = ~dir_q;
                end else begin
                    dir_d = 1'b0;
                    sq_d  = ~sq_q;
                end
            end else if (!mode[i]) begin
                dir_d = 1'b0;
                if (cnt_q >= div) begin
                    cnt_d  = WIDTH'(1);
                    tick_d = 1'b1;
                    sq_d   = ~sq_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (!dir_q) begin
                    if (cnt_q >= div) begin
                        dir_d  = 1'b1;
                        tick_d = 1'b1;
                        cnt_d  = cnt_q - WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end else begin
                    if (cnt_q <= WIDTH'(1)) begin
                        dir_d = 1'b0;
                        cnt_d = WIDTH'(2);
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                sq_d = dir_d;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= WIDTH'(1);
                dir_q  <= 1'b0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                dir_q  <= dir_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt_q;
        assign tick[i]                 = tick_q;
        assign square[i]               = sq_q;
    end

endmodule

// File: tb/tb_multi_oscillator.sv
// Self-checking bench for multi_oscillator: directed scenarios plus randomized run
// against a behavioural model of the per-channel waveform rules.
module tb_multi_oscillator;

    localparam int W = 16;
    localparam int C = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [C-1:0]     en;
    logic [C-1:0]     mode;
    logic [C-1:0]     sync_v;
    logic [C*W-1:0]   divider;
    logic [C*W-1:0]   count;
    logic [C-1:0]     tick;
    logic [C-1:0]     square;

    int passed = 0;
    int total  = 0;

    // Model state per channel
    int m_cnt  [C];
    bit m_dir  [C];
    bit m_tick [C];
    bit m_sq   [C];

    always #5 clk = ~clk;

    multi_oscillator #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
`ifdef OSC_SYNC_EN
        .sync    (sync_v),
`endif
        .divider (divider),
        .count   (count),
        .tick    (tick),
        .square  (square)
    );

    function automatic int dut_cnt(input int ch);
        return int'(count[ch*W +: W]);
    endfunction

    task automatic set_div(input int ch, input int val);
        divider[ch*W +: W] = W'(val);
    endtask

    // Next-state of every channel computed from the waveform rules with integers.
    task automatic model_update();
        bit sy;
        int d;
        for (int ch = 0; ch < C; ch++) begin
`ifdef OSC_SYNC_EN
            sy = sync_v[ch];
`else
            sy = 1'b0;
`endif
            d = int'(divider[ch*W +: W]);
            m_tick[ch] = 1'b0;
            if (rst || !en[ch] || sy) begin
                m_cnt[ch] = 1; m_dir[ch] = 0; m_sq[ch] = 0;
            end else if (d <= 1) begin
                m_cnt[ch] = 1; m_tick[ch] = 1;
                if (mode[ch]) begin
                    m_dir[ch] = !m_dir[ch]; m_sq[ch] = m_dir[ch];
                end else begin
                    m_dir[ch] = 0; m_sq[ch] = !m_sq[ch];
                end
            end else if (!mode[ch]) begin
                m_dir[ch] = 0;
                if (m_cnt[ch] >= d) begin
                    m_cnt[ch] = 1; m_tick[ch] = 1; m_sq[ch] = !m_sq[ch];
                end else begin
                    m_cnt[ch] = m_cnt[ch] + 1;
                end
            end else begin
                if (!m_dir[ch] && m_cnt[ch] >= d) begin
                    m_dir[ch] = 1; m_tick[ch] = 1; m_cnt[ch] = m_cnt[ch] - 1;
                end else if (!m_dir[ch]) begin
                    m_cnt[ch] = m_cnt[ch] + 1;
                end else if (m_cnt[ch] <= 1) begin
                    m_dir[ch] = 0; m_cnt[ch] = 2;
                end else begin
                    m_cnt[ch] = m_cnt[ch] - 1;
                end
                m_sq[ch] = m_dir[ch];
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 4'hF; mode = '0; sync_v = '0; divider = '0;
        set_div(0, 4); set_div(1, 4); set_div(2, 4); set_div(3, 4);
        do_reset();
        total++;
        if (count !== {C{16'd1}}) $display("FAIL reset_count got=%h want=%h", count, {C{16'd1}});
        else passed++;
        total++;
        if (tick !== 4'h0 || square !== 4'h0)
            $display("FAIL reset_tick_square got=%b/%b want=0000/0000", tick, square);
        else passed++;
        step();
        total++;
        if (dut_cnt(0) !== 2) $display("FAIL reset_release got=%0d want=2", dut_cnt(0));
        else passed++;
    endtask

    task automatic test_saw();
        int ec [8];
        bit et [8];
        bit es [8];
        ec = '{2, 3, 4, 1, 2, 3, 4, 1};
        et = '{0, 0, 0, 1, 0, 0, 0, 1};
        es = '{0, 0, 0, 1, 1, 1, 1, 0};
        en = 4'h1; mode = '0; set_div(0, 4);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if (dut_cnt(0) !== ec[k] || tick[0] !== et[k] || square[0] !== es[k])
                $display("FAIL saw_step%0d got=%0d/%b/%b want=%0d/%b/%b", k, dut_cnt(0),
                         tick[0], square[0], ec[k], et[k], es[k]);
            else passed++;
        end
    endtask

    task automatic test_triangle();
        int ec [9];
        bit et [9];
        bit es [9];
        ec = '{2, 3, 4, 3, 2, 1, 2, 3, 4};
        et = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        es = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        en = 4'h2; mode = 4'h2; set_div(1, 4);
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step();
            total++;
            if (dut_cnt(1) !== ec[k] || tick[1] !== et[k] || square[1] !== es[k])
                $display("FAIL tri_step%0d got=%0d/%b/%b want=%0d/%b/%b", k, dut_cnt(1),
                         tick[1], square[1], ec[k], et[k], es[k]);
            else passed++;
        end
    endtask

    task automatic test_divider_change();
        bit sq3;
        en = 4'hC; mode = '0; set_div(2, 10); set_div(3, 0);
        do_reset();
        sq3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            sq3 = !sq3;
            total++;
            if (dut_cnt(3) !== 1 || tick[3] !== 1'b1 || square[3] !== sq3)
                $display("FAIL div0_step%0d got=%0d/%b/%b want=1/1/%b", k, dut_cnt(3),
                         tick[3], square[3], sq3);
            else passed++;
        end
        total++;
        if (dut_cnt(2) !== 7) $display("FAIL divchg_pre got=%0d want=7", dut_cnt(2));
        else passed++;
        set_div(2, 3);
        step();
        total++;
        if (dut_cnt(2) !== 1 || tick[2] !== 1'b1)
            $display("FAIL divchg_wrap got=%0d/%b want=1/1", dut_cnt(2), tick[2]);
        else passed++;
    endtask

    task automatic test_enable_drop();
        en = 4'hF; mode = 4'h2; set_div(0, 4); set_div(1, 5); set_div(2, 6); set_div(3, 3);
        do_reset();
        step();
        step();
        total++;
        if (dut_cnt(0) !== 3) $display("FAIL endrop_pre got=%0d want=3", dut_cnt(0));
        else passed++;
        en[0] = 1'b0;
        step();
        total++;
        if (dut_cnt(0) !== 1 || square[0] !== 1'b0 || tick[0] !== 1'b0)
            $display("FAIL endrop_ch0 got=%0d/%b/%b want=1/0/0", dut_cnt(0), square[0], tick[0]);
        else passed++;
        for (int ch = 1; ch < C; ch++) begin
            total++;
            if (dut_cnt(ch) !== m_cnt[ch] || tick[ch] !== m_tick[ch] || square[ch] !== m_sq[ch])
                $display("FAIL endrop_ch%0d got=%0d want=%0d", ch, dut_cnt(ch), m_cnt[ch]);
            else passed++;
        end
        en[0] = 1'b1;
        step();
        total++;
        if (dut_cnt(0) !== 2) $display("FAIL endrop_resume got=%0d want=2", dut_cnt(0));
        else passed++;
    endtask

    task automatic test_sync();
        int ec [3];
        en = 4'h2; mode = 4'h2; set_div(1, 4); sync_v = '0;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        total++;
        if (dut_cnt(1) !== 3 || square[1] !== 1'b1)
            $display("FAIL sync_pre got=%0d/%b want=3/1", dut_cnt(1), square[1]);
        else passed++;
`ifdef OSC_SYNC_EN
        sync_v[1] = 1'b1;
        step();
        sync_v[1] = 1'b0;
        total++;
        if (dut_cnt(1) !== 1 || square[1] !== 1'b0)
            $display("FAIL sync_hit got=%0d/%b want=1/0", dut_cnt(1), square[1]);
        else passed++;
        ec = '{2, 3, 4};
`else
        ec = '{2, 1, 2};
`endif
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (dut_cnt(1) !== ec[k])
                $display("FAIL sync_post%0d got=%0d want=%0d", k, dut_cnt(1), ec[k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        en = 4'hF; mode = '0; sync_v = '0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int ch = 0; ch < C; ch++) begin
                en[ch] = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 19) == 0) mode[ch] = !mode[ch];
                if ($urandom_range(0, 9) == 0) begin
                    if ($urandom_range(0, 9) == 0) set_div(ch, 16'hFFFF);
                    else set_div(ch, int'($urandom_range(0, 9)));
                end
`ifdef OSC_SYNC_EN
                sync_v[ch] = ($urandom_range(0, 29) == 0);
`endif
            end
            step();
            for (int ch = 0; ch < C; ch++) begin
                total++;
                if (dut_cnt(ch) !== m_cnt[ch] || tick[ch] !== m_tick[ch]
                    || square[ch] !== m_sq[ch]) begin
                    if (errs < 10)
                        $display("FAIL rand_c%0d_ch%0d got=%0d/%b/%b want=%0d/%b/%b", cyc, ch,
                                 dut_cnt(ch), tick[ch], square[ch], m_cnt[ch], m_tick[ch],
                                 m_sq[ch]);
                    errs++;
                end else passed++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = '0; sync_v = '0; divider = '0;
        for (int ch = 0; ch < C; ch++) begin
            m_cnt[ch] = 1; m_dir[ch] = 0; m_tick[ch] = 0; m_sq[ch] = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_saw();
        test_triangle();
        test_divider_change();
        test_enable_drop();
        test_sync();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
